rand_layout_gen: RTL and testbench
==================================

# rand_layout_gen

Seeded layout generator for the teeter game. It produces MAX_NUM non-overlapping sprite positions: the fail holes, then the win hole, then the ball start. Results are packed into one flat bus that the game control state machine latches in its GAME_NEW state. It sits directly upstream of that state machine, replacing free-running position generation with rejection sampling and pairwise separation checks.

## Interface
- MAX_NUM, 9, number of positions; entry MAX_NUM-2 = win hole, MAX_NUM-1 = ball start, rest = fail holes
- POS_X_RANGE, 288, x coordinates drawn from 0..POS_X_RANGE-1
- POS_Y_RANGE, 148, y coordinates drawn from 0..POS_Y_RANGE-1
- MIN_DIST, 32, required separation per axis
- MAX_TRIES, 64, candidate rejections allowed per entry before forced accept
- COORD_W, 10, coordinate width; POS_X_RANGE and POS_Y_RANGE must each be ≤ 2^COORD_W
- i_clk  input  1  system clock (100 MHz)
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  one-cycle pulse: load seed, begin generation
- i_seed  input  16  seed, sampled on i_start
- o_rand_list  output  2*COORD_W*MAX_NUM  packed result
  - entry k x at [COORD_W*k +: COORD_W]
  - entry k y at [COORD_W*(MAX_NUM+k) +: COORD_W]
- o_data_ready  output  1  high while o_rand_list holds a complete layout
- o_busy  output  1  high while generating
- o_relaxed  output  1  sticky per run: at least one entry was force-accepted

## Operation
- Reset values: all outputs 0; state IDLE; LFSR = 16'hACE1.
- LFSR:
  - 16-bit Galois, right shift, tap mask 16'hB400.
  - Advances exactly one step per cycle in GEN_X and GEN_Y only.
  - A seed of 0 is replaced by 16'hACE1.
- States:
  - IDLE: o_busy=0. i_start → SEED.
  - SEED: load LFSR; clear entry index k, try counter, o_relaxed, o_data_ready, o_rand_list → GEN_X.
  - GEN_X: candidate = LFSR low $clog2(POS_X_RANGE) bits. If < POS_X_RANGE, latch cx → GEN_Y. Otherwise stay and resample.
  - GEN_Y: same rule with POS_Y_RANGE; latch cy → CHECK. If k==0, go → ACCEPT instead.
  - CHECK: compares the candidate against accepted entry j, one entry per cycle, j = 0..k-1.
    - Conflict if |cx-xj| < MIN_DIST and |cy-yj| < MIN_DIST.
    - Conflict with tries < MAX_TRIES-1: tries+1 → GEN_X.
    - Conflict with tries == MAX_TRIES-1: set o_relaxed → ACCEPT.
    - No conflict at j = k-1 → ACCEPT.
  - ACCEPT: write cx/cy into entry k; tries = 0; k+1. If k == MAX_NUM-1 → DONE, else → GEN_X.
  - DONE: o_data_ready=1, o_busy=0. Holds the layout until the next i_start.
- Differences are computed unsigned as (a>b ? a-b : b-a), COORD_W bits wide.
- i_start in any state, including mid-generation or DONE → SEED. The partial layout is discarded and o_data_ready drops.
- o_rand_list bits for entries not yet accepted read 0 during generation.

## Timing
- i_start high in cycle 0 → SEED in cycle 1 → o_busy=1 from cycle 2.
- Each entry with no resamples and no conflicts takes 3 + k cycles: GEN_X, GEN_Y, k CHECK cycles, ACCEPT.
- Best case, MAX_NUM=9: o_data_ready rises at cycle 2 + Σ(3+k) = 2 + 27 + 36 = 65.
- o_data_ready and the final entry update in the same cycle.
- Consumers may sample o_rand_list on any cycle where o_data_ready=1.
- The async reset asserts immediately and deasserts synchronously through a 2-flop synchronizer.

## Configuration
- RAND_LAYOUT_SEPARATION_EN
  - Defined: CHECK state and the try counter are present, as described above.
  - Undefined: GEN_Y always goes → ACCEPT; o_relaxed is tied 0; best-case latency is 2 + 3*MAX_NUM cycles.

## Test plan
- Reset: assert i_rst_n=0 mid-run → all outputs 0 on the same edge. After release with no i_start, outputs stay 0.
- Seed zero: i_start with i_seed=0 → layout identical to i_start with i_seed=16'hACE1.
- Golden run: i_seed=16'h1234, defaults → every x < 288, every y < 148, and every pair separated by ≥32 on at least one axis. Bit-exact match with the C model.
- Restart: i_start with i_seed=16'h1234, then i_start again at cycle 20 → o_data_ready falls. Final layout equals an uninterrupted run with the second seed.
- Forced relax: MIN_DIST=200, MAX_TRIES=4 → o_data_ready rises within bounded cycles and o_relaxed=1. The next i_start clears o_relaxed.
- Macro off: i_seed=16'h0001 → o_data_ready at cycle 29 when no resamples occur (2 + 3*9) and o_relaxed=0.

Source files
------------

// File: rtl/rand_layout_gen.sv
// rand_layout_gen: seeded layout generator for the teeter game.
// Produces MAX_NUM sprite positions (fail holes, then the win hole, then the
// ball start) using a 16-bit Galois LFSR with rejection sampling. The layout is
// packed onto one flat bus that the game controller latches when
// o_data_ready is high.
//
// Optional feature macro: RAND_LAYOUT_SEPARATION_EN
//   defined   - each candidate is checked against every accepted entry, one
//               entry per cycle. A candidate that lands too close is redrawn,
//               up to MAX_TRIES attempts per entry before it is force-accepted
//               (o_relaxed flags this).
//   undefined - candidates are accepted as drawn; o_relaxed is tied low.
module rand_layout_gen #(
  parameter int MAX_NUM     = 9,
  parameter int POS_X_RANGE = 288,
  parameter int POS_Y_RANGE = 148,
  parameter int MIN_DIST    = 32,
  parameter int MAX_TRIES   = 64,
  parameter int COORD_W     = 10
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic [15:0]                  i_seed,
  output logic [2*COORD_W*MAX_NUM-1:0] o_rand_list,
  output logic                         o_data_ready,
  output logic                         o_busy,
  output logic                         o_relaxed
);

  localparam int IDX_W = (MAX_NUM > 1) ? $clog2(MAX_NUM) : 1;
  localparam int XB    = (POS_X_RANGE > 1) ? $clog2(POS_X_RANGE) : 1;
  localparam int YB    = (POS_Y_RANGE > 1) ? $clog2(POS_Y_RANGE) : 1;
  localparam int K_LAST_I = MAX_NUM - 1;

  localparam logic [15:0]        LFSR_INIT = 16'hACE1;
  localparam logic [15:0]        LFSR_TAPS = 16'hB400;
  localparam logic [COORD_W:0]   X_LIM     = POS_X_RANGE[COORD_W:0];
  localparam logic [COORD_W:0]   Y_LIM     = POS_Y_RANGE[COORD_W:0];
  localparam logic [IDX_W-1:0]   K_LAST    = K_LAST_I[IDX_W-1:0];

  // Reject parameter sets the datapath cannot represent.
  if (MAX_NUM < 1 || MIN_DIST < 1 || MAX_TRIES < 1 ||
      POS_X_RANGE < 1 || POS_Y_RANGE < 1 ||
      POS_X_RANGE > (1 << COORD_W) || POS_Y_RANGE > (1 << COORD_W)) begin : g_bad_cfg
    $error("rand_layout_gen: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_GEN_X,
    ST_GEN_Y,
    ST_CHECK,
    ST_ACCEPT,
    ST_DONE
  } state_t;

  // Reset synchronizer: asserts immediately, releases two clocks after i_rst_n rises.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_q[1];

  state_t             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [15:0]        seed_q, seed_d;
  logic [IDX_W-1:0]   k_q, k_d;
  logic [COORD_W-1:0] cx_q, cx_d;
  logic [COORD_W-1:0] cy_q, cy_d;
  logic [COORD_W-1:0] x_q [MAX_NUM];
  logic [COORD_W-1:0] x_d [MAX_NUM];
  logic [COORD_W-1:0] y_q [MAX_NUM];
  logic [COORD_W-1:0] y_d [MAX_NUM];
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  logic [15:0]        lfsr_step;
  logic [COORD_W-1:0] cand_x;
  logic [COORD_W-1:0] cand_y;
  logic               cand_x_ok;
  logic               cand_y_ok;

`ifdef RAND_LAYOUT_SEPARATION_EN
  localparam int TRY_W      = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam int TRY_LAST_I = MAX_TRIES - 1;
  localparam logic [TRY_W-1:0]   TRY_LAST = TRY_LAST_I[TRY_W-1:0];
  localparam logic [COORD_W-1:0] MIN_D    = MIN_DIST[COORD_W-1:0];

  logic [IDX_W-1:0]   j_q, j_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic               relaxed_q, relaxed_d;
  logic [COORD_W-1:0] dx;
  logic [COORD_W-1:0] dy;
  logic               conflict;

  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Candidate versus the accepted entry currently being examined.
  assign dx       = abs_diff(cx_q, x_q[j_q]);
  assign dy       = abs_diff(cy_q, y_q[j_q]);
  assign conflict = (dx < MIN_D) && (dy < MIN_D);
`endif

  // One Galois step and the candidate coordinates drawn from the current LFSR value.
  always_comb begin
    lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    cand_x = '0;
    cand_x[XB-1:0] = lfsr_q[XB-1:0];
    cand_y = '0;
    cand_y[YB-1:0] = lfsr_q[YB-1:0];
    cand_x_ok = ({1'b0, cand_x} < X_LIM);
    cand_y_ok = ({1'b0, cand_y} < Y_LIM);
  end

  // Next-state logic for the sequencer and all datapath registers.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    seed_d  = seed_q;
    k_d     = k_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    x_d     = x_q;
    y_d     = y_q;
`ifdef RAND_LAYOUT_SEPARATION_EN
    j_d       = j_q;
    tries_d   = tries_q;
    relaxed_d = relaxed_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
      end

      ST_SEED: begin
        lfsr_d = (seed_q == 16'h0000) ? LFSR_INIT : seed_q;
        k_d    = '0;
        x_d    = '{default: '0};
        y_d    = '{default: '0};
`ifdef RAND_LAYOUT_SEPARATION_EN
        tries_d   = '0;
        relaxed_d = 1'b0;
`endif
        state_d = ST_GEN_X;
      end

      ST_GEN_X: begin
        lfsr_d = lfsr_step;
        if (cand_x_ok) begin
          cx_d    = cand_x;
          state_d = ST_GEN_Y;
        end
      end

      ST_GEN_Y: begin
        lfsr_d = lfsr_step;
        if (cand_y_ok) begin
          cy_d = cand_y;
`ifdef RAND_LAYOUT_SEPARATION_EN
          if (k_q == '0) begin
            state_d = ST_ACCEPT;
          end else begin
            j_d     = '0;
            state_d = ST_CHECK;
          end
`else
          state_d = ST_ACCEPT;
`endif
        end
      end

`ifdef RAND_LAYOUT_SEPARATION_EN
      ST_CHECK: begin
        if (conflict) begin
          if (tries_q < TRY_LAST) begin
            tries_d = tries_q + 1'b1;
            state_d = ST_GEN_X;
          end else begin
            relaxed_d = 1'b1;
            state_d   = ST_ACCEPT;
          end
        end else if ((j_q + 1'b1) == k_q) begin
          state_d = ST_ACCEPT;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
`endif

      ST_ACCEPT: begin
        x_d[k_q] = cx_q;
        y_d[k_q] = cy_q;
        k_d      = k_q + 1'b1;
`ifdef RAND_LAYOUT_SEPARATION_EN
        tries_d = '0;
`endif
        state_d = (k_q == K_LAST) ? ST_DONE : ST_GEN_X;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A start pulse wins from any state; the old layout is dropped at once.
    if (i_start) begin
      state_d = ST_SEED;
      seed_d  = i_seed;
      x_d     = '{default: '0};
      y_d     = '{default: '0};
`ifdef RAND_LAYOUT_SEPARATION_EN
      relaxed_d = 1'b0;
`endif
    end

    busy_d  = (state_d inside {ST_GEN_X, ST_GEN_Y, ST_CHECK, ST_ACCEPT});
    ready_d = (state_d == ST_DONE);
  end

  // State and datapath registers; outputs are registered copies.
  always_ff @(posedge i_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q <= ST_IDLE;
      lfsr_q  <= LFSR_INIT;
      seed_q  <= '0;
      k_q     <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      x_q     <= '{default: '0};
      y_q     <= '{default: '0};
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef RAND_LAYOUT_SEPARATION_EN
      j_q       <= '0;
      tries_q   <= '0;
      relaxed_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      seed_q  <= seed_d;
      k_q     <= k_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
`ifdef RAND_LAYOUT_SEPARATION_EN
      j_q       <= j_d;
      tries_q   <= tries_d;
      relaxed_q <= relaxed_d;
`endif
    end
  end

  // Flatten the entry registers onto the result bus: all x first, then all y.
  for (genvar gi = 0; gi < MAX_NUM; gi++) begin : g_pack
    assign o_rand_list[COORD_W*gi +: COORD_W]             = x_q[gi];
    assign o_rand_list[COORD_W*(MAX_NUM+gi) +: COORD_W]   = y_q[gi];
  end

  assign o_data_ready = ready_q;
  assign o_busy       = busy_q;
`ifdef RAND_LAYOUT_SEPARATION_EN
  assign o_relaxed = relaxed_q;
`else
  assign o_relaxed = 1'b0;
`endif

endmodule

// File: tb/tb_rand_layout_gen.sv
// Self-checking bench for rand_layout_gen: a behavioural model predicts each
// layout, its completion cycle and the relaxed flag; predictions are queued
// when a start is driven and compared when o_data_ready rises.
module tb_rand_layout_gen;

  localparam int MAX_NUM = 9;
  localparam int XR      = 288;
  localparam int YR      = 148;
  localparam int CW      = 10;
  localparam int LIST_W  = 2 * CW * MAX_NUM;
  localparam int XB      = $clog2(XR);
  localparam int YB      = $clog2(YR);
  localparam int BUDGET  = 8000;
`ifdef RAND_LAYOUT_SEPARATION_EN
  localparam bit SEP = 1'b1;
`else
  localparam bit SEP = 1'b0;
`endif

  typedef struct {
    logic [LIST_W-1:0] list;
    int                cycles;
    bit                relaxed;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   failures;
  int   sel;

  logic              clk;
  logic              rst_n;
  logic              d_start, r_start;
  logic [15:0]       d_seed, r_seed;
  logic [LIST_W-1:0] d_list, r_list;
  logic              d_ready, r_ready;
  logic              d_busy, r_busy;
  logic              d_rlx, r_rlx;

  logic [LIST_W-1:0] cur_list;
  logic              cur_ready, cur_busy, cur_rlx;

  rand_layout_gen dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (d_start),
    .i_seed       (d_seed),
    .o_rand_list  (d_list),
    .o_data_ready (d_ready),
    .o_busy       (d_busy),
    .o_relaxed    (d_rlx)
  );

  rand_layout_gen #(.MIN_DIST(200), .MAX_TRIES(4)) dut_rlx (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (r_start),
    .i_seed       (r_seed),
    .o_rand_list  (r_list),
    .o_data_ready (r_ready),
    .o_busy       (r_busy),
    .o_relaxed    (r_rlx)
  );

  assign cur_list  = (sel == 1) ? r_list  : d_list;
  assign cur_ready = (sel == 1) ? r_ready : d_ready;
  assign cur_busy  = (sel == 1) ? r_busy  : d_busy;
  assign cur_rlx   = (sel == 1) ? r_rlx   : d_rlx;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic int absd(input int a, input int b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Behavioural model: cycles counts from the start pulse (cycle 0).
  function automatic exp_t model(input logic [15:0] seed, input int min_dist, input int max_tries);
    exp_t        e;
    logic [15:0] l;
    int          xs[MAX_NUM];
    int          ys[MAX_NUM];
    int          cx, cy, c, tries;
    bit          conflict, done;
    e.list    = '0;
    e.cycles  = 2;
    e.relaxed = 1'b0;
    cx = 0;
    cy = 0;
    l = (seed == 16'h0000) ? 16'hACE1 : seed;
    for (int k = 0; k < MAX_NUM; k++) begin
      tries = 0;
      done  = 1'b0;
      while (!done) begin
        do begin
          e.cycles++;
          c = int'(l) & ((1 << XB) - 1);
          l = lfsr_next(l);
        end while (c >= XR);
        cx = c;
        do begin
          e.cycles++;
          c = int'(l) & ((1 << YB) - 1);
          l = lfsr_next(l);
        end while (c >= YR);
        cy = c;
        conflict = 1'b0;
        if (SEP && k > 0) begin
          for (int j = 0; j < k && !conflict; j++) begin
            e.cycles++;
            if (absd(cx, xs[j]) < min_dist && absd(cy, ys[j]) < min_dist) conflict = 1'b1;
          end
        end
        if (!conflict) begin
          done = 1'b1;
        end else if (tries < max_tries - 1) begin
          tries++;
        end else begin
          e.relaxed = 1'b1;
          done = 1'b1;
        end
      end
      e.cycles++;
      xs[k] = cx;
      ys[k] = cy;
      e.list[CW*k +: CW]           = CW'(cx);
      e.list[CW*(MAX_NUM+k) +: CW] = CW'(cy);
    end
    return e;
  endfunction

  // Start pulse high for one full cycle; returns at the negedge after it was sampled.
  task automatic drive_start(input int w, input logic [15:0] seed);
    @(negedge clk);
    if (w == 1) begin r_start = 1'b1; r_seed = seed; end
    else        begin d_start = 1'b1; d_seed = seed; end
    @(negedge clk);
    r_start = 1'b0;
    d_start = 1'b0;
  endtask

  // Range and separation properties of a finished layout.
  task automatic check_layout(input string tag, input logic [LIST_W-1:0] l, input bit relaxed);
    int bad_range;
    int bad_sep;
    bad_range = 0;
    bad_sep   = 0;
    for (int i = 0; i < MAX_NUM; i++) begin
      if (int'(l[CW*i +: CW]) >= XR || int'(l[CW*(MAX_NUM+i) +: CW]) >= YR) bad_range++;
      for (int j = 0; j < i; j++) begin
        if (absd(int'(l[CW*i +: CW]), int'(l[CW*j +: CW])) < 32 &&
            absd(int'(l[CW*(MAX_NUM+i) +: CW]), int'(l[CW*(MAX_NUM+j) +: CW])) < 32) bad_sep++;
      end
    end
    check_val({tag, "_range"}, 256'(bad_range), 256'(0));
    if (SEP && !relaxed) check_val({tag, "_sep"}, 256'(bad_sep), 256'(0));
  endtask

  // One generation run; with abort_at > 0 the first seed is restarted at that cycle.
  task automatic run_gen(input int w, input logic [15:0] seed, input string tag,
                         input int abort_at, input logic [15:0] seed2);
    int          n;
    exp_t        e;
    logic [15:0] fs;
    sel = w;
    fs  = (abort_at > 0) ? seed2 : seed;
    sb_q.push_back(model(fs, (w == 1) ? 200 : 32, (w == 1) ? 4 : 64));
    if (abort_at > 0) begin
      drive_start(w, seed);
      check_val({tag, "_ready_drop"}, 256'(cur_ready), 256'(0));
      repeat (abort_at - 2) @(negedge clk);
    end
    drive_start(w, fs);
    n = 1;
    while (!cur_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
      if (n == 2) begin
        check_val({tag, "_busy_c2"}, 256'(cur_busy), 256'(1));
        check_val({tag, "_list_clr"}, 256'(cur_list), 256'(0));
        check_val({tag, "_rlx_clr"}, 256'(cur_rlx), 256'(0));
      end
    end
    e = sb_q.pop_front();
    check_val({tag, "_ready"}, 256'(cur_ready), 256'(1));
    check_val({tag, "_cycles"}, 256'(n), 256'(e.cycles));
    check_val({tag, "_list"}, 256'(cur_list), 256'(e.list));
    check_val({tag, "_relaxed"}, 256'(cur_rlx), 256'(e.relaxed));
    check_val({tag, "_busy_done"}, 256'(cur_busy), 256'(0));
    if (w == 0) check_layout(tag, cur_list, e.relaxed);
    $display("txn %s seed=%h cycles=%0d exp_cycles=%0d relaxed=%0b", tag, fs, n, e.cycles, cur_rlx);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    sel      = 0;
    rst_n    = 1'b0;
    d_start  = 1'b0;
    r_start  = 1'b0;
    d_seed   = '0;
    r_seed   = '0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_val("rst_list", 256'(d_list), 256'(0));
    check_val("rst_ready", 256'(d_ready), 256'(0));
    check_val("rst_busy", 256'(d_busy), 256'(0));
    check_val("rst_relaxed", 256'(d_rlx), 256'(0));
    $display("txn reset_idle done");

    run_gen(0, 16'h1234, "golden", 0, 16'h0000);
    run_gen(0, 16'h0000, "seed_zero", 0, 16'h0000);
    run_gen(0, 16'hACE1, "seed_ace1", 0, 16'h0000);
    run_gen(0, 16'h1234, "restart", 20, 16'h5A5A);
    run_gen(0, 16'h0001, "seed_0001", 0, 16'h0000);
    run_gen(0, 16'hBEEF, "seed_beef", 0, 16'h0000);

    // Asynchronous reset in the middle of a run.
    sel = 0;
    drive_start(0, 16'h7777);
    repeat (9) @(negedge clk);
    check_val("mid_busy", 256'(d_busy), 256'(1));
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_list", 256'(d_list), 256'(0));
    check_val("arst_ready", 256'(d_ready), 256'(0));
    check_val("arst_busy", 256'(d_busy), 256'(0));
    check_val("arst_relaxed", 256'(d_rlx), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_val("post_rst_list", 256'(d_list), 256'(0));
    check_val("post_rst_ready", 256'(d_ready), 256'(0));
    check_val("post_rst_busy", 256'(d_busy), 256'(0));
    $display("txn async_reset_midrun done");

    run_gen(1, 16'h1234, "relax", 0, 16'h0000);
    run_gen(1, 16'h0042, "relax_next", 0, 16'h0000);
    run_gen(0, 16'hFFFF, "seed_ffff", 0, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
